ehl_gray_counter: RTL and testbench
===================================

Name: ehl_gray_counter

Overview:
- Parameterised up-counter that holds its state as a registered Gray code and also exposes the binary equivalent.
- Also exposes the next-state values in both codes.
- Used as a FIFO read/write pointer generator: the registered Gray output crosses clock domains safely, and the binary output drives local address and credit arithmetic.
- Gray-to-binary conversion is done by a reusable combinational sub-module.

Parameters:
- DEPTH, default 4: counter width in bits; legal range 1..32.
- RANGE, default 16 (1<<DEPTH): count modulus; counts 0..RANGE-1 then wraps to 0; legal range 2..2**DEPTH.

Ports:
- clk  input  1  clock, rising edge.
- res  input  1  synchronous, active-high reset.
- ena  input  1  count enable; advances the counter by one on a clk edge.
- gcnt  output  DEPTH  registered Gray-coded count.
- bcnt  output  DEPTH  binary equivalent of gcnt (combinational from gcnt).
- gcnt_next  output  DEPTH  Gray value gcnt takes at the next clk edge.
- bcnt_next  output  DEPTH  binary value bcnt takes at the next clk edge.

Behaviour:
- State: a single DEPTH-bit Gray register, gcnt. There is no separate binary register.
- bcnt = gray2bin(gcnt):
  - b[DEPTH-1] = g[DEPTH-1];
  - b[i] = b[i+1] ^ g[i] for each lower bit i.
- Increment: inc = (bcnt == RANGE-1) ? 0 : bcnt + 1, computed at DEPTH bits.
- bcnt_next = ena ? inc : bcnt.
- gcnt_next = bcnt_next ^ (bcnt_next >> 1).
- On posedge clk:
  - res = 1: gcnt <= 0. res has priority over ena.
  - otherwise: gcnt <= gcnt_next.
- Reset values: gcnt = 0, bcnt = 0. gcnt_next = bcnt_next = 1 if ena = 1, else 0 (DEPTH >= 1).
- Latency: gcnt/bcnt change one clk after ena is sampled high. The *_next outputs change combinationally with ena.
- Wrap-around:
  - RANGE == 2**DEPTH: wraps 2**DEPTH-1 -> 0 and remains single-bit-change Gray.
  - RANGE < 2**DEPTH: wraps RANGE-1 -> 0. The Gray single-bit-change property at this wrap is not guaranteed; the counter still functions.
- A count above RANGE-1 is unreachable from reset.
- ena held high: gcnt changes every cycle, exactly one bit per step except at a non-power-of-2 wrap.
- Reset asserted mid-count: the counter returns to 0 on the next edge regardless of ena.
- No combinational path from clk or res to outputs other than through gcnt.

Decomposition:
- No shared package is needed. The only constant is the increment of 1; the widths come from parameters.
- Sub-module ehl_gray_to_bin: parameter WIDTH, default 4; input data_gray[WIDTH-1:0]; output data_bin[WIDTH-1:0]; purely combinational XOR-prefix conversion.
- ehl_gray_counter instantiates ehl_gray_to_bin once, to derive bcnt.
- Binary-to-Gray is a one-line expression inside the counter.

Test Plan:
1. Reset: res=1 for 2 cycles with ena=1 -> gcnt=0, bcnt=0 throughout; after res deasserts, gcnt_next=1 and bcnt_next=1.
2. Full sequence, DEPTH=4, RANGE=16, ena=1 for 17 cycles -> gcnt steps 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0 (hex). bcnt steps 0..15,0. Each step has Hamming distance 1.
3. Enable hold: ena=0 for 5 cycles at bcnt=6 -> gcnt stays 0x5, bcnt_next=6, gcnt_next=0x5. When ena rises, gcnt_next=0x4 combinationally.
4. Non-power-of-2 range, DEPTH=3, RANGE=6, ena=1 -> bcnt cycles 0,1,2,3,4,5,0. gcnt goes 0,1,3,2,6,7,0. The value 7 wraps straight to 0.
5. Mid-count reset: count to bcnt=9, then assert res with ena=1 -> bcnt=0 next edge; counting resumes 1,2,... after release.
6. Converter exhaustive, ehl_gray_to_bin WIDTH=5: drive all 32 Gray codes of b -> data_bin == b for every b.

Source files
------------

// File: rtl/ehl_gray_to_bin.sv
// ehl_gray_to_bin: combinational Gray-to-binary converter.
// Each binary bit is the XOR of its own Gray bit and every Gray bit above it.
// This gives the same result as b[i] = b[i+1] ^ g[i], but without a chain of
// one bit feeding the next.
module ehl_gray_to_bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_gray,
  output logic [WIDTH-1:0] data_bin
);

  // Prefix-XOR reduction, one output bit per generate iteration
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign data_bin[i] = ^(data_gray >> i);
  end

endmodule

// File: rtl/ehl_gray_counter.sv
// ehl_gray_counter: modulo-RANGE up-counter whose only state is a Gray register.
// gcnt is safe to hand across a clock domain; bcnt is its binary decode and is
// used for local address and credit arithmetic. The *_next outputs show the
// value the counter takes at the coming edge, which lets a FIFO compare
// full/empty one cycle early.
module ehl_gray_counter #(
  parameter int unsigned     DEPTH = 4,
  parameter longint unsigned RANGE = 64'd1 << DEPTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic             ena,
  output logic [DEPTH-1:0] gcnt,
  output logic [DEPTH-1:0] bcnt,
  output logic [DEPTH-1:0] gcnt_next,
  output logic [DEPTH-1:0] bcnt_next
);

  // Terminal count and step, both held at counter width so that the
  // comparison and the add need no extension.
  localparam logic [DEPTH-1:0] LAST = DEPTH'(RANGE - 64'd1);
  localparam logic [DEPTH-1:0] STEP = DEPTH'(1);

  if (DEPTH < 1 || DEPTH > 32) begin : g_bad_depth
    $error("ehl_gray_counter: DEPTH must be in 1..32");
  end
  if (RANGE < 2 || RANGE > (64'd1 << DEPTH)) begin : g_bad_range
    $error("ehl_gray_counter: RANGE must be in 2..2**DEPTH");
  end

  logic [DEPTH-1:0] inc;

  // Decode the Gray register. This is the only binary view of the count.
  ehl_gray_to_bin #(
    .WIDTH (DEPTH)
  ) u_g2b (
    .data_gray (gcnt),
    .data_bin  (bcnt)
  );

  // Next-state: the increment wraps at RANGE-1, is held when ena is low, and is
  // re-encoded to Gray. When RANGE is not a power of two, the wrap step can
  // change more than one Gray bit.
  always_comb begin
    inc       = (bcnt == LAST) ? '0 : bcnt + STEP;
    bcnt_next = ena ? inc : bcnt;
    gcnt_next = bcnt_next ^ (bcnt_next >> 1);
  end

  // State register. Reset takes priority over the enable.
  always_ff @(posedge clk) begin
    if (res) gcnt <= '0;
    else     gcnt <= gcnt_next;
  end

endmodule

// File: tb/tb_ehl_gray_counter.sv
module tb_ehl_gray_counter;

  logic       clk = 1'b0;
  logic       res, ena, res6, ena6;
  logic [3:0] gcnt, bcnt, gcnt_next, bcnt_next;
  logic [2:0] g6, b6, gn6, bn6;
  logic [4:0] cv_g, cv_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ehl_gray_counter #(.DEPTH(4), .RANGE(16)) dut (
    .clk(clk), .res(res), .ena(ena),
    .gcnt(gcnt), .bcnt(bcnt), .gcnt_next(gcnt_next), .bcnt_next(bcnt_next)
  );

  ehl_gray_counter #(.DEPTH(3), .RANGE(6)) dut6 (
    .clk(clk), .res(res6), .ena(ena6),
    .gcnt(g6), .bcnt(b6), .gcnt_next(gn6), .bcnt_next(bn6)
  );

  ehl_gray_to_bin #(.WIDTH(5)) conv (
    .data_gray(cv_g), .data_bin(cv_b)
  );

  typedef struct packed {
    logic       res;
    logic       ena;
    logic [3:0] g;
    logic [3:0] b;
    logic [3:0] gn;
    logic [3:0] bn;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic e, logic [3:0] g, logic [3:0] b,
                             logic [3:0] gn, logic [3:0] bn);
    vec_t t;
    t.res = r; t.ena = e; t.g = g; t.b = b; t.gn = gn; t.bn = bn;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Counting steps with ena=1, res=0 from state b (Gray g) to b+1
  task automatic add_step(input int k);
    case (k)
      0:  tbl.push_back(v(0, 1, 4'h0, 4'h0, 4'h1, 4'h1));
      1:  tbl.push_back(v(0, 1, 4'h1, 4'h1, 4'h3, 4'h2));
      2:  tbl.push_back(v(0, 1, 4'h3, 4'h2, 4'h2, 4'h3));
      3:  tbl.push_back(v(0, 1, 4'h2, 4'h3, 4'h6, 4'h4));
      4:  tbl.push_back(v(0, 1, 4'h6, 4'h4, 4'h7, 4'h5));
      5:  tbl.push_back(v(0, 1, 4'h7, 4'h5, 4'h5, 4'h6));
      6:  tbl.push_back(v(0, 1, 4'h5, 4'h6, 4'h4, 4'h7));
      7:  tbl.push_back(v(0, 1, 4'h4, 4'h7, 4'hC, 4'h8));
      8:  tbl.push_back(v(0, 1, 4'hC, 4'h8, 4'hD, 4'h9));
      9:  tbl.push_back(v(0, 1, 4'hD, 4'h9, 4'hF, 4'hA));
      10: tbl.push_back(v(0, 1, 4'hF, 4'hA, 4'hE, 4'hB));
      11: tbl.push_back(v(0, 1, 4'hE, 4'hB, 4'hA, 4'hC));
      12: tbl.push_back(v(0, 1, 4'hA, 4'hC, 4'hB, 4'hD));
      13: tbl.push_back(v(0, 1, 4'hB, 4'hD, 4'h9, 4'hE));
      14: tbl.push_back(v(0, 1, 4'h9, 4'hE, 4'h8, 4'hF));
      default: tbl.push_back(v(0, 1, 4'h8, 4'hF, 4'h0, 4'h0));
    endcase
  endtask

  initial begin
    logic [3:0] prev;
    logic [2:0] exp_b6 [7];
    logic [2:0] exp_g6 [7];
    logic [4:0] gray;

    res = 1'b1; ena = 1'b0; res6 = 1'b1; ena6 = 1'b0; cv_g = '0;

    // Reset held with ena high: state stays 0, next shows 1
    tbl.push_back(v(1, 1, 4'h0, 4'h0, 4'h1, 4'h1));
    tbl.push_back(v(1, 1, 4'h0, 4'h0, 4'h1, 4'h1));
    // Full 16-state sequence plus wrap back to 0
    for (int k = 0; k <= 16; k++) add_step(k % 16);
    // Advance 1 -> 6
    for (int k = 1; k <= 5; k++) add_step(k);
    // Hold at 6 for 5 cycles
    for (int k = 0; k < 5; k++) tbl.push_back(v(0, 0, 4'h5, 4'h6, 4'h5, 4'h6));
    // Enable rises at 6, then advance to 9
    add_step(6); add_step(7); add_step(8);
    // Mid-count reset at 9 with ena high
    tbl.push_back(v(1, 1, 4'hD, 4'h9, 4'hF, 4'hA));
    // Resume counting from 0
    add_step(0); add_step(1); add_step(2);

    @(posedge clk); @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      res = tbl[i].res;
      ena = tbl[i].ena;
      #1;
      chk($sformatf("v%0d gcnt", i),      32'(gcnt),      32'(tbl[i].g));
      chk($sformatf("v%0d bcnt", i),      32'(bcnt),      32'(tbl[i].b));
      chk($sformatf("v%0d gcnt_next", i), 32'(gcnt_next), 32'(tbl[i].gn));
      chk($sformatf("v%0d bcnt_next", i), 32'(bcnt_next), 32'(tbl[i].bn));
      prev = gcnt;
      @(posedge clk);
      @(negedge clk);
      if (tbl[i].ena && !tbl[i].res)
        chk($sformatf("v%0d hamming", i), 32'($countones(gcnt ^ prev)), 32'd1);
    end
    res = 1'b0; ena = 1'b0;

    // Non-power-of-2 range: DEPTH=3, RANGE=6
    exp_b6 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    exp_g6 = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd0};
    res6 = 1'b0; ena6 = 1'b1;
    #1;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("r6 step%0d bcnt", k), 32'(b6), 32'(exp_b6[k]));
      chk($sformatf("r6 step%0d gcnt", k), 32'(g6), 32'(exp_g6[k]));
      if (k == 5) begin
        chk("r6 wrap bcnt_next", 32'(bn6), 32'd0);
        chk("r6 wrap gcnt_next", 32'(gn6), 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    ena6 = 1'b0;

    // Converter exhaustive over all 5-bit codes
    for (int b = 0; b < 32; b++) begin
      gray = 5'(b) ^ (5'(b) >> 1);
      cv_g = gray;
      #1;
      chk($sformatf("g2b %0d", b), 32'(cv_b), 32'(b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
